// File: rtl/if_stage_pkg.sv
// Shared rv32i definitions for the fetch stage: instruction width, the
// canonical NOP, base opcodes and a word-alignment helper.
package if_stage_pkg;

    localparam int          INSN_W   = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;   // addi x0, x0, 0

    // Base opcodes (kept here so decode can share them instead of duplicating)
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Clear the two byte-offset bits of an address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle for the fetch stage: instruction-memory port, decode handshake
// and redirect input. master = fetch stage, slave = its environment.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                redirect;
    logic [31:0]         redirect_pc;
    logic                id_ready;
    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_ack;
    logic [INSN_W-1:0]   imem_rdata;
    logic [INSN_W-1:0]   ir;
    logic [31:0]         pc;
    logic                if_valid;

    modport master (
        input  redirect, redirect_pc, id_ready, imem_ack, imem_rdata,
        output imem_req, imem_addr, ir, pc, if_valid
    );

    modport slave (
        output redirect, redirect_pc, id_ready, imem_ack, imem_rdata,
        input  imem_req, imem_addr, ir, pc, if_valid
    );

endinterface

// File: rtl/if_stage.sv
// rv32i instruction-fetch stage. Issues one word fetch at a time, hands the
// word to decode with valid/ready, and follows branch/jump redirects. A
// redirect that arrives while a request is outstanding cannot cancel it
// (the address must stay stable until ack), so the target is parked in
// pending_pc_r and the returning word is dropped.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    fetch_state_e       state_r,      state_s;
    logic [31:0]        fetch_pc_r,   fetch_pc_s;
    logic [31:0]        pending_pc_r, pending_pc_s;
    logic               discard_r,    discard_s;
    logic [INSN_W-1:0]  ir_r,         ir_s;
    logic [31:0]        pc_r,         pc_s;
    logic               if_valid_r,   if_valid_s;
    logic [31:0]        target_s;

    // Next-state and datapath decisions for the fetch FSM.
    always_comb begin
        state_s      = state_r;
        fetch_pc_s   = fetch_pc_r;
        pending_pc_s = pending_pc_r;
        discard_s    = discard_r;
        ir_s         = ir_r;
        pc_s         = pc_r;
        if_valid_s   = if_valid_r;
        target_s     = word_align(bus.redirect_pc);

        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                if (bus.redirect) begin
                    fetch_pc_s = target_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
            end

            ST_FETCH: begin
                if (bus.imem_ack) begin
                    if (discard_r || bus.redirect) begin
                        // Wrong-path word: drop it and refetch from the newest target.
                        discard_s  = 1'b0;
                        fetch_pc_s = bus.redirect ? target_s : pending_pc_r;
                    end else begin
                        ir_s       = bus.imem_rdata;
                        pc_s       = fetch_pc_r;
                        if_valid_s = 1'b1;
                        fetch_pc_s = fetch_pc_r + 32'd4;
                        state_s    = ST_HOLD;
                    end
                end else if (bus.redirect) begin
                    // Request still in flight: remember the target, keep the address.
                    pending_pc_s = target_s;
                    discard_s    = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (bus.redirect) begin
                    if_valid_s = 1'b0;
                    ir_s       = NOP_INSN;
                    fetch_pc_s = target_s;
                    state_s    = ST_FETCH;
                end else if (bus.id_ready) begin
                    if_valid_s = 1'b0;
                    ir_s       = NOP_INSN;
                    state_s    = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                if_valid_s = 1'b0;
                ir_s       = NOP_INSN;
                discard_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fetch_pc_r   <= word_align(RESET_PC);
            pending_pc_r <= word_align(RESET_PC);
            discard_r    <= 1'b0;
            ir_r         <= NOP_INSN;
            pc_r         <= word_align(RESET_PC);
            if_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            fetch_pc_r   <= fetch_pc_s;
            pending_pc_r <= pending_pc_s;
            discard_r    <= discard_s;
            ir_r         <= ir_s;
            pc_r         <= pc_s;
            if_valid_r   <= if_valid_s;
        end
    end

    assign bus.imem_req  = (state_r == ST_FETCH);
    assign bus.imem_addr = fetch_pc_r;
    assign bus.ir        = ir_r;
    assign bus.pc        = pc_r;
    assign bus.if_valid  = if_valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: straight-line stimulus with hand-derived
// expectations. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side memory contents: an easily recognisable function of address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus.id_ready      = 1'b0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0;

        cyc(); cyc();
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_ir",    bus.ir, NOP_INSN);
        chk("rst_pc",    bus.pc, 32'h0);

        // ---- 1: zero-wait acks, decode always ready ----
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        cyc();                                  // IDLE -> FETCH
        chk("t1_req0",  {31'd0, bus.imem_req}, 32'd1);
        chk("t1_addr0", bus.imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem(32'(i * 4));
            cyc();
            bus.imem_ack = 1'b0;
            chk("t1_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("t1_pc",    bus.pc, 32'(i * 4));
            chk("t1_ir",    bus.ir, mem(32'(i * 4)));
            chk("t1_noreq", {31'd0, bus.imem_req}, 32'd0);
            cyc();
            chk("t1_gap_valid", {31'd0, bus.if_valid}, 32'd0);
            chk("t1_gap_ir",    bus.ir, NOP_INSN);
            chk("t1_next_addr", bus.imem_addr, 32'(i * 4 + 4));
        end

        // ---- 2: decode stall for 5 cycles ----
        bus.id_ready   = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0050_0093;
        cyc();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("t2_ir",    bus.ir, 32'h0050_0093);
            chk("t2_pc",    bus.pc, 32'h0000_000C);
            chk("t2_req",   {31'd0, bus.imem_req}, 32'd0);
            cyc();
        end
        chk("t2_stall_end_valid", {31'd0, bus.if_valid}, 32'd1);
        bus.id_ready = 1'b1;
        cyc();
        chk("t2_rel_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t2_rel_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("t2_rel_addr",  bus.imem_addr, 32'h10);

        // ---- 3: ack delayed 3 cycles, redirect in 2nd wait cycle ----
        cyc();
        chk("t3_w1_addr", bus.imem_addr, 32'h10);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        cyc();
        bus.redirect = 1'b0;
        chk("t3_w2_addr",  bus.imem_addr, 32'h10);
        chk("t3_w2_req",   {31'd0, bus.imem_req}, 32'd1);
        cyc();
        chk("t3_w3_addr",  bus.imem_addr, 32'h10);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem(32'h10);
        cyc();
        chk("t3_drop_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t3_new_addr",   bus.imem_addr, 32'h100);
        chk("t3_new_req",    {31'd0, bus.imem_req}, 32'd1);
        bus.imem_rdata = mem(32'h100);
        bus.id_ready   = 1'b0;
        cyc();
        bus.imem_ack = 1'b0;
        chk("t3_tgt_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("t3_tgt_pc",    bus.pc, 32'h100);
        chk("t3_tgt_ir",    bus.ir, mem(32'h100));

        // ---- 4: redirect in HOLD together with id_ready ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        bus.id_ready    = 1'b1;
        cyc();
        bus.redirect = 1'b0;
        chk("t4_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t4_ir",    bus.ir, NOP_INSN);
        chk("t4_addr",  bus.imem_addr, 32'h200);

        // ---- 5: wrap of fetch_pc at top of address space ----
        bus.redirect    = 1'b1;                 // ack + redirect: drop word at 0x200
        bus.redirect_pc = 32'hFFFF_FFFC;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = mem(32'h200);
        cyc();
        bus.redirect = 1'b0;
        chk("t5_drop_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t5_addr_top",   bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_rdata = mem(32'hFFFF_FFFC);
        cyc();
        bus.imem_ack = 1'b0;
        chk("t5_top_pc",    bus.pc, 32'hFFFF_FFFC);
        chk("t5_top_valid", {31'd0, bus.if_valid}, 32'd1);
        cyc();
        chk("t5_wrap_addr", bus.imem_addr, 32'h0);

        // ---- multiple redirects in one outstanding request: last wins ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        cyc();
        chk("mr_addr1", bus.imem_addr, 32'h0);
        bus.redirect_pc = 32'h80;
        cyc();
        bus.redirect = 1'b0;
        chk("mr_addr2", bus.imem_addr, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem(32'h0);
        cyc();
        chk("mr_drop_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("mr_new_addr",   bus.imem_addr, 32'h80);
        bus.imem_rdata = mem(32'h80);
        cyc();
        bus.imem_ack = 1'b0;
        chk("mr_pc",    bus.pc, 32'h80);
        chk("mr_valid", {31'd0, bus.if_valid}, 32'd1);
        cyc();
        chk("mr_next_addr", bus.imem_addr, 32'h84);

        // ---- 6: asynchronous reset mid-FETCH ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("t6_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t6_pc",    bus.pc, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_restart_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("t6_restart_addr", bus.imem_addr, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem(32'h0);
        cyc();
        bus.imem_ack = 1'b0;
        chk("t6_first_pc",    bus.pc, 32'h0);
        chk("t6_first_valid", {31'd0, bus.if_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
